// File: rtl/ex_alu.sv
`default_nettype none
// ============================================================================
//  Module   : ex_alu
//  Purpose  : RV32IM integer ALU (add/logic/compare/shift/mul/div) with a
//             single registered output stage and a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module ex_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      func,
  output logic [XLEN-1:0] result,
  output logic            valid_out
);

  localparam logic [4:0] c_ALU_ADD    = 5'd0;
  localparam logic [4:0] c_ALU_SUB    = 5'd1;
  localparam logic [4:0] c_ALU_AND    = 5'd2;
  localparam logic [4:0] c_ALU_OR     = 5'd3;
  localparam logic [4:0] c_ALU_XOR    = 5'd4;
  localparam logic [4:0] c_ALU_SLT    = 5'd5;
  localparam logic [4:0] c_ALU_SLTU   = 5'd6;
  localparam logic [4:0] c_ALU_SLL    = 5'd7;
  localparam logic [4:0] c_ALU_SRL    = 5'd8;
  localparam logic [4:0] c_ALU_SRA    = 5'd9;
  localparam logic [4:0] c_ALU_MUL    = 5'd10;
  localparam logic [4:0] c_ALU_MULH   = 5'd11;
  localparam logic [4:0] c_ALU_MULHSU = 5'd12;
  localparam logic [4:0] c_ALU_MULHU  = 5'd13;
  localparam logic [4:0] c_ALU_DIV    = 5'd14;
  localparam logic [4:0] c_ALU_DIVU   = 5'd15;
  localparam logic [4:0] c_ALU_REM    = 5'd16;
  localparam logic [4:0] c_ALU_REMU   = 5'd17;

  logic [4:0]  w_shamt;
  logic        w_a_sext;
  logic        w_b_sext;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;

  logic        w_sdiv;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  logic [31:0] w_res;
  logic [31:0] r_result;
  logic        r_valid;

  assign w_shamt = opb[4:0];

  // 33x33 signed product; extending the 33-bit operands to 64 bits keeps all
  // 64 meaningful product bits exact.
  assign w_a_sext = (func == c_ALU_MULH) || (func == c_ALU_MULHSU);
  assign w_b_sext = (func == c_ALU_MULH);
  assign w_ma     = {{32{w_a_sext & opa[31]}}, opa};
  assign w_mb     = {{32{w_b_sext & opb[31]}}, opb};
  assign w_prod   = w_ma * w_mb;

  // Sign-magnitude division; the overflow case (-2^31 / -1) falls out
  // naturally because negating 0x80000000 yields 0x80000000.
  assign w_sdiv   = (func == c_ALU_DIV) || (func == c_ALU_REM);
  assign w_a_neg  = w_sdiv & opa[31];
  assign w_b_neg  = w_sdiv & opb[31];
  assign w_b_zero = (opb == 32'd0);
  assign w_abs_a  = w_a_neg ? (~opa + 32'd1) : opa;
  assign w_abs_b  = w_b_neg ? (~opb + 32'd1) : opb;
  assign w_den    = w_b_zero ? 32'd1 : w_abs_b;
  assign w_uq     = w_abs_a / w_den;
  assign w_ur     = w_abs_a % w_den;
  assign w_quot   = w_b_zero ? 32'hFFFF_FFFF :
                    ((w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq);
  assign w_rem    = w_b_zero ? opa :
                    (w_a_neg ? (~w_ur + 32'd1) : w_ur);

  always_comb begin
    w_res = 32'd0;
    case (func)
      c_ALU_ADD:    w_res = opa + opb;
      c_ALU_SUB:    w_res = opa - opb;
      c_ALU_AND:    w_res = opa & opb;
      c_ALU_OR:     w_res = opa | opb;
      c_ALU_XOR:    w_res = opa ^ opb;
      c_ALU_SLT:    w_res = {31'd0, ($signed(opa) < $signed(opb))};
      c_ALU_SLTU:   w_res = {31'd0, (opa < opb)};
      c_ALU_SLL:    w_res = opa << w_shamt;
      c_ALU_SRL:    w_res = opa >> w_shamt;
      c_ALU_SRA:    w_res = $unsigned($signed(opa) >>> w_shamt);
      c_ALU_MUL:    w_res = w_prod[31:0];
      c_ALU_MULH,
      c_ALU_MULHSU,
      c_ALU_MULHU:  w_res = w_prod[63:32];
      c_ALU_DIV,
      c_ALU_DIVU:   w_res = w_quot;
      c_ALU_REM,
      c_ALU_REMU:   w_res = w_rem;
      default:      w_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 32'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_result <= w_res;
      end
    end
  end

  assign result    = r_result;
  assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_alu
//  Purpose  : Directed self-checking bench for ex_alu.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_alu;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  AND_ = 5'd2, OR_ = 5'd3;
  localparam logic [4:0] XOR_ = 5'd4, SLT = 5'd5,  SLTU = 5'd6, SLL = 5'd7;
  localparam logic [4:0] SRL = 5'd8,  SRA = 5'd9,  MUL = 5'd10, MULH = 5'd11;
  localparam logic [4:0] MULHSU = 5'd12, MULHU = 5'd13, DIV = 5'd14;
  localparam logic [4:0] DIVU = 5'd15, REM = 5'd16, REMU = 5'd17, RSV = 5'd18;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  func;
  logic [31:0] result;
  logic        valid_out;

  int n_vec  = 0;
  int n_miss = 0;

  ex_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .opa       (opa),
    .opb       (opb),
    .func      (func),
    .result    (result),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp_res, input logic exp_vld);
    n_vec++;
    assert (result === exp_res) else begin
      n_miss++;
      $error("FAIL %s result: observed %h expected %h", tag, result, exp_res);
    end
    assert (valid_out === exp_vld) else begin
      n_miss++;
      $error("FAIL %s valid_out: observed %b expected %b", tag, valid_out, exp_vld);
    end
  endtask

  // Drive one operation at the falling edge, check it just after the next rising edge.
  task automatic op(input string tag, input logic [4:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_res);
    @(negedge clk);
    valid_in = 1'b1;
    func     = f;
    opa      = a;
    opb      = b;
    @(posedge clk);
    #1;
    check(tag, exp_res, 1'b1);
  endtask

  task automatic idle(input string tag, input logic [31:0] held);
    @(negedge clk);
    valid_in = 1'b0;
    opa      = 32'hDEAD_BEEF;
    opb      = 32'h1234_5678;
    func     = ADD;
    @(posedge clk);
    #1;
    check(tag, held, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    opa      = 32'd0;
    opb      = 32'd0;
    func     = ADD;
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op("add_pre", ADD, 32'd40, 32'd2, 32'd42);
    // Asynchronous reset between edges, with an operation still being driven.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'd0, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 32'd0, 1'b0);

    op("mul_100x115",   MUL,    32'd100,       32'd115,       32'h0000_2CEC);
    op("mulhu_small",   MULHU,  32'd100,       32'd115,       32'h0000_0000);
    op("mulh_m1m1",     MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    op("mulhu_m1m1",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    op("mulhsu_m1m1",   MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op("mul_m1m1",      MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    op("mulhsu_min_x2", MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF);
    op("mulh_min_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

    op("div_by0",       DIV,    32'd7,         32'd0,         32'hFFFF_FFFF);
    op("divu_by0",      DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF);
    op("rem_by0",       REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    op("remu_by0",      REMU,   32'd7,         32'd0,         32'd7);
    op("div_ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    op("rem_ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    op("div_m7_2",      DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    op("rem_m7_2",      REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    op("div_7_m2",      DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    op("rem_7_m2",      REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001);
    op("divu_big",      DIVU,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF);
    op("remu_big",      REMU,   32'hFFFF_FFFF, 32'd2,         32'h0000_0001);

    op("sra_min_36",    SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    op("srl_min_36",    SRL,    32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    op("sll_1_63",      SLL,    32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
    op("slt_m1_1",      SLT,    32'hFFFF_FFFF, 32'd1,         32'd1);
    op("sltu_m1_1",     SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0);
    op("slt_1_m1",      SLT,    32'd1,         32'hFFFF_FFFF, 32'd0);
    op("sltu_1_m1",     SLTU,   32'd1,         32'hFFFF_FFFF, 32'd1);
    op("sub_0_1",       SUB,    32'd0,         32'd1,         32'hFFFF_FFFF);
    op("add_wrap",      ADD,    32'hFFFF_FFFF, 32'd2,         32'h0000_0001);
    op("and",           AND_,   32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    op("or",            OR_,    32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011);
    op("reserved",      RSV,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);

    // Back-to-back issue, then an idle cycle that must hold the last result.
    op("pipe_add",      ADD,    32'd5,         32'd3,         32'd8);
    op("pipe_sub",      SUB,    32'd5,         32'd3,         32'd2);
    op("pipe_xor",      XOR_,   32'd5,         32'd3,         32'd6);
    idle("pipe_idle", 32'd6);
    idle("pipe_idle2", 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
